// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined LEGv8 CPU: register-address width,
// the hard-wired zero register and the writeback-select encoding.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 31;
  localparam int unsigned DATA_W     = 64;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC4 = 2'd2
  } memToReg_t;

endpackage

// File: rtl/pipe_field_reg.sv
// One field of a pipeline stage register: synchronous reset, synchronous clear
// (bubble insert) and load enable; reset outranks clear, clear outranks enable.
module pipe_field_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memwr_stage_reg.sv
// MEM/WB pipeline register with stall, flush and forwarding-hit detection
// against NUM_SRC source operands currently in EX.
module memwr_stage_reg
  import cpu_pkg::REG_ADDR_W;
  import cpu_pkg::memToReg_t;
#(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          validIn,
  input  logic                          regWrite,
  input  logic [REG_ADDR_W-1:0]         Rd,
  input  memToReg_t                     memToReg,
  input  logic [DATA_W-1:0]             aluResult,
  input  logic [DATA_W-1:0]             memData,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] srcAddr,
  output logic                          validOut,
  output logic                          regWriteOut,
  output logic [REG_ADDR_W-1:0]         RdOut,
  output memToReg_t                     memToRegOut,
  output logic [DATA_W-1:0]             aluResultOut,
  output logic [DATA_W-1:0]             memDataOut,
  output logic [NUM_SRC-1:0]            fwdHit
);

  localparam int unsigned MTR_W = 2;

  logic             load_en;
  logic             reg_write_qual;
  logic [MTR_W-1:0] mtr_q;

  assign load_en = ~stall;

  // Bubbles and writes to XZR must never look like live writes downstream.
  assign reg_write_qual = regWrite & validIn & (Rd != REG_ADDR_W'(ZERO_REG));

  pipe_field_reg #(.WIDTH(1)) u_valid (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d(validIn), .q(validOut)
  );

  pipe_field_reg #(.WIDTH(1)) u_reg_write (
    .clk(clk), .reset(reset), .en(load_en), .clr(flush),
    .d(reg_write_qual), .q(regWriteOut)
  );

  pipe_field_reg #(.WIDTH(REG_ADDR_W)) u_rd (
    .clk(clk), .reset(reset), .en(load_en), .clr(1'b0),
    .d(Rd), .q(RdOut)
  );

  pipe_field_reg #(.WIDTH(MTR_W)) u_mem_to_reg (
    .clk(clk), .reset(reset), .en(load_en), .clr(1'b0),
    .d(MTR_W'(memToReg)), .q(mtr_q)
  );

  assign memToRegOut = memToReg_t'(mtr_q);

  pipe_field_reg #(.WIDTH(DATA_W)) u_alu_result (
    .clk(clk), .reset(reset), .en(load_en), .clr(1'b0),
    .d(aluResult), .q(aluResultOut)
  );

  pipe_field_reg #(.WIDTH(DATA_W)) u_mem_data (
    .clk(clk), .reset(reset), .en(load_en), .clr(1'b0),
    .d(memData), .q(memDataOut)
  );

  // XZR never hits because regWriteOut is already qualified against it.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    assign fwdHit[i] = regWriteOut & validOut &
                       (RdOut == srcAddr[i*REG_ADDR_W +: REG_ADDR_W]);
  end

endmodule

// File: tb/tb_memwr_stage_reg.sv
// Self-checking bench for memwr_stage_reg: directed scenarios plus randomized
// traffic compared against a cycle-level reference model.
module tb_memwr_stage_reg;
  import cpu_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned NS = 2;

  logic              clk = 1'b0;
  logic              reset, stall, flush, validIn, regWrite;
  logic [4:0]        Rd;
  memToReg_t         memToReg;
  logic [DW-1:0]     aluResult, memData;
  logic [NS*5-1:0]   srcAddr;
  logic              validOut, regWriteOut;
  logic [4:0]        RdOut;
  memToReg_t         memToRegOut;
  logic [DW-1:0]     aluResultOut, memDataOut;
  logic [NS-1:0]     fwdHit;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the stage should hold after each edge.
  logic          m_v, m_rw;
  logic [4:0]    m_rd;
  logic [1:0]    m_mtr;
  logic [DW-1:0] m_alu, m_mem;

  memwr_stage_reg #(.DATA_W(DW), .NUM_SRC(NS), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .validIn(validIn), .regWrite(regWrite), .Rd(Rd), .memToReg(memToReg),
    .aluResult(aluResult), .memData(memData), .srcAddr(srcAddr),
    .validOut(validOut), .regWriteOut(regWriteOut), .RdOut(RdOut),
    .memToRegOut(memToRegOut), .aluResultOut(aluResultOut),
    .memDataOut(memDataOut), .fwdHit(fwdHit)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_v = 0; m_rw = 0; m_rd = 0; m_mtr = 0; m_alu = 0; m_mem = 0;
    end else if (flush) begin
      m_v = 0; m_rw = 0;
    end else if (!stall) begin
      m_v   = validIn;
      m_rw  = regWrite && validIn && (Rd != 5'd31);
      m_rd  = Rd;
      m_mtr = 2'(memToReg);
      m_alu = aluResult;
      m_mem = memData;
    end
    #1;
  endtask

  function automatic logic [NS-1:0] exp_hit();
    logic [NS-1:0] h;
    h = '0;
    for (int i = 0; i < NS; i++)
      if (m_v && m_rw && srcAddr[i*5 +: 5] == m_rd) h[i] = 1'b1;
    return h;
  endfunction

  task automatic set_live(input logic [4:0] rd);
    validIn = 1; regWrite = 1; Rd = rd;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; flush = 1; validIn = 1; regWrite = 1; Rd = 5'd6;
    memToReg = MTR_PC4; aluResult = '1; memData = '1; srcAddr = {5'd6, 5'd6};
    tick();
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL reset_valid got %0h exp 0", validOut); end
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("FAIL reset_rw got %0h exp 0", regWriteOut); end
    checks++; if (RdOut !== 5'd0) begin failures++; $display("FAIL reset_rd got %0h exp 0", RdOut); end
    checks++; if (memToRegOut !== MTR_ALU) begin failures++; $display("FAIL reset_mtr got %0h exp 0", memToRegOut); end
    checks++; if (aluResultOut !== '0) begin failures++; $display("FAIL reset_alu got %0h exp 0", aluResultOut); end
    checks++; if (memDataOut !== '0) begin failures++; $display("FAIL reset_mem got %0h exp 0", memDataOut); end
    checks++; if (fwdHit !== 2'b00) begin failures++; $display("FAIL reset_fwd got %0b exp 00", fwdHit); end
    reset = 0; stall = 0; flush = 0;
  endtask

  task automatic test_load();
    set_live(5'd5); aluResult = 64'h1234; memToReg = MTR_MEM; memData = 64'hBEEF;
    tick();
    checks++; if (validOut !== 1'b1) begin failures++; $display("FAIL load_valid got %0h exp 1", validOut); end
    checks++; if (regWriteOut !== 1'b1) begin failures++; $display("FAIL load_rw got %0h exp 1", regWriteOut); end
    checks++; if (RdOut !== 5'd5) begin failures++; $display("FAIL load_rd got %0d exp 5", RdOut); end
    checks++; if (aluResultOut !== 64'h1234) begin failures++; $display("FAIL load_alu got %0h exp 1234", aluResultOut); end
    checks++; if (memToRegOut !== MTR_MEM) begin failures++; $display("FAIL load_mtr got %0h exp 1", memToRegOut); end
    checks++; if (memDataOut !== 64'hBEEF) begin failures++; $display("FAIL load_mem got %0h exp beef", memDataOut); end
  endtask

  task automatic test_stall();
    set_live(5'd7);
    tick();
    checks++; if (RdOut !== 5'd7) begin failures++; $display("FAIL stall_pre_rd got %0d exp 7", RdOut); end
    stall = 1; Rd = 5'd9; aluResult = 64'h9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (RdOut !== 5'd7) begin failures++; $display("FAIL stall_hold_rd cyc%0d got %0d exp 7", i, RdOut); end
      checks++; if (validOut !== 1'b1) begin failures++; $display("FAIL stall_hold_valid cyc%0d got %0h exp 1", i, validOut); end
    end
    stall = 0;
    tick();
    checks++; if (RdOut !== 5'd9) begin failures++; $display("FAIL stall_release_rd got %0d exp 9", RdOut); end
  endtask

  task automatic test_flush_over_stall();
    set_live(5'd3); srcAddr = {5'd0, 5'd3};
    tick();
    checks++; if (fwdHit !== 2'b01) begin failures++; $display("FAIL flush_pre_fwd got %0b exp 01", fwdHit); end
    flush = 1; stall = 1;
    tick();
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL flush_valid got %0h exp 0", validOut); end
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("FAIL flush_rw got %0h exp 0", regWriteOut); end
    checks++; if (fwdHit !== 2'b00) begin failures++; $display("FAIL flush_fwd got %0b exp 00", fwdHit); end
    flush = 0; stall = 0;
  endtask

  task automatic test_qualification();
    set_live(5'd31); srcAddr = {5'd31, 5'd4};
    tick();
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("FAIL xzr_rw got %0h exp 0", regWriteOut); end
    checks++; if (fwdHit !== 2'b00) begin failures++; $display("FAIL xzr_fwd got %0b exp 00", fwdHit); end
    set_live(5'd4); validIn = 0;
    tick();
    checks++; if (regWriteOut !== 1'b0) begin failures++; $display("FAIL bubble_rw got %0h exp 0", regWriteOut); end
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL bubble_valid got %0h exp 0", validOut); end
    checks++; if (fwdHit !== 2'b00) begin failures++; $display("FAIL bubble_fwd got %0b exp 00", fwdHit); end
  endtask

  task automatic test_forwarding();
    set_live(5'd10); srcAddr = {5'd10, 5'd10};
    tick();
    checks++; if (fwdHit !== 2'b11) begin failures++; $display("FAIL fwd_both got %0b exp 11", fwdHit); end
    srcAddr = {5'd11, 5'd10};
    #1;
    checks++; if (fwdHit !== 2'b01) begin failures++; $display("FAIL fwd_slot1_change got %0b exp 01", fwdHit); end
    srcAddr = {5'd10, 5'd2};
    #1;
    checks++; if (fwdHit !== 2'b10) begin failures++; $display("FAIL fwd_slot0_change got %0b exp 10", fwdHit); end
  endtask

  task automatic test_reset_mid_stall();
    set_live(5'd12);
    tick();
    stall = 1; Rd = 5'd13;
    tick();
    reset = 1;
    tick();
    checks++; if (validOut !== 1'b0) begin failures++; $display("FAIL rst_stall_valid got %0h exp 0", validOut); end
    checks++; if (RdOut !== 5'd0) begin failures++; $display("FAIL rst_stall_rd got %0d exp 0", RdOut); end
    reset = 0; stall = 0;
    tick();
    checks++; if (RdOut !== 5'd13) begin failures++; $display("FAIL rst_stall_reload_rd got %0d exp 13", RdOut); end
    checks++; if (regWriteOut !== 1'b1) begin failures++; $display("FAIL rst_stall_reload_rw got %0h exp 1", regWriteOut); end
  endtask

  task automatic test_random();
    logic [NS-1:0] eh;
    for (int n = 0; n < 500; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      validIn  = ($urandom_range(0, 4) != 0);
      regWrite = ($urandom_range(0, 3) != 0);
      Rd       = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
      memToReg = memToReg_t'(2'($urandom_range(0, 2)));
      aluResult = {$urandom, $urandom};
      memData   = {$urandom, $urandom};
      srcAddr   = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      tick();
      checks++; if (validOut !== m_v) begin failures++; $display("FAIL rnd_valid n=%0d got %0h exp %0h", n, validOut, m_v); end
      checks++; if (regWriteOut !== m_rw) begin failures++; $display("FAIL rnd_rw n=%0d got %0h exp %0h", n, regWriteOut, m_rw); end
      if (m_v) begin
        checks++; if (RdOut !== m_rd) begin failures++; $display("FAIL rnd_rd n=%0d got %0d exp %0d", n, RdOut, m_rd); end
        checks++; if (2'(memToRegOut) !== m_mtr) begin failures++; $display("FAIL rnd_mtr n=%0d got %0h exp %0h", n, memToRegOut, m_mtr); end
        checks++; if (aluResultOut !== m_alu) begin failures++; $display("FAIL rnd_alu n=%0d got %0h exp %0h", n, aluResultOut, m_alu); end
        checks++; if (memDataOut !== m_mem) begin failures++; $display("FAIL rnd_mem n=%0d got %0h exp %0h", n, memDataOut, m_mem); end
      end
      eh = exp_hit();
      checks++; if (fwdHit !== eh) begin failures++; $display("FAIL rnd_fwd n=%0d got %0b exp %0b", n, fwdHit, eh); end
      // Steer a slot at the held destination to exercise hits mid-cycle.
      srcAddr[5*$urandom_range(0, NS-1) +: 5] = m_rd;
      #1;
      eh = exp_hit();
      checks++; if (fwdHit !== eh) begin failures++; $display("FAIL rnd_fwd_comb n=%0d got %0b exp %0b", n, fwdHit, eh); end
    end
    reset = 0; flush = 0; stall = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_qualification();
    test_forwarding();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
